// File: rtl/icap_pkg.sv
// Shared encodings and ICAP command words for the multiboot reboot initiator.
// Pure declarations: no logic, no latency, no flow control.
package icap_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    localparam logic [15:0] ICAP_DUMMY      = 16'hFFFF;
    localparam logic [15:0] ICAP_SYNC       = 16'hAA99;
    localparam logic [15:0] ICAP_WR_GEN1    = 16'h3261;
    localparam logic [15:0] ICAP_WR_GEN2    = 16'h3281;
    localparam logic [15:0] ICAP_WR_CMD     = 16'h30A1;
    localparam logic [15:0] ICAP_CMD_REBOOT = 16'h000E;
    localparam logic [15:0] ICAP_NOOP       = 16'h2000;

    localparam int SEQ_BYTES = 20;

    function automatic logic [7:0] bit_rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/icap_seq_rom.sv
// Byte lookup for the reboot command stream; purely combinational, no backpressure.
// Words go out high byte first; the ICAP port wants each byte bit-reversed when BIT_SWAP is set.
module icap_seq_rom
    import icap_pkg::*;
#(
    parameter bit         BIT_SWAP    = 1'b1,
    parameter logic [7:0] READ_OPCODE = 8'h0B
) (
    input  logic [4:0]  idx_i,
    input  logic [23:0] boot_addr_i,
    output logic [7:0]  byte_o
);

    logic [15:0] seq_word;
    logic [7:0]  raw_byte;

    always_comb begin
        seq_word = 16'h0000;
        case (idx_i[4:1])
            4'd0:    seq_word = ICAP_DUMMY;
            4'd1:    seq_word = ICAP_SYNC;
            4'd2:    seq_word = ICAP_WR_GEN1;
            4'd3:    seq_word = boot_addr_i[15:0];
            4'd4:    seq_word = ICAP_WR_GEN2;
            4'd5:    seq_word = {READ_OPCODE, boot_addr_i[23:16]};
            4'd6:    seq_word = ICAP_WR_CMD;
            4'd7:    seq_word = ICAP_CMD_REBOOT;
            4'd8:    seq_word = ICAP_NOOP;
            4'd9:    seq_word = ICAP_NOOP;
            default: seq_word = 16'h0000;
        endcase
        raw_byte = idx_i[0] ? seq_word[7:0] : seq_word[15:8];
        byte_o   = BIT_SWAP ? bit_rev8(raw_byte) : raw_byte;
    end

endmodule

// File: rtl/icap_reboot_wb_master.sv
// Wishbone initiator streaming the 20-byte multiboot reboot sequence into the ICAP slave.
// One write per byte, one idle gap cycle between strobes; waits up to TIMEOUT cycles per ack.
module icap_reboot_wb_master
    import icap_pkg::*;
#(
    parameter int         TIMEOUT     = 255,
    parameter bit         BIT_SWAP    = 1'b1,
    parameter logic [7:0] READ_OPCODE = 8'h0B
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] boot_addr,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] dat_o,
    input  logic        ack_i,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state_q, state_d;
    logic [4:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [23:0]   addr_q, addr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          req_q, req_d;
    logic [7:0]    dat_q, dat_d;
    logic [7:0]    rom_byte;

    // Indexed by the next-state values so the bus data is registered alongside stb.
    icap_seq_rom #(
        .BIT_SWAP    (BIT_SWAP),
        .READ_OPCODE (READ_OPCODE)
    ) u_rom (
        .idx_i       (idx_d),
        .boot_addr_i (addr_d),
        .byte_o      (rom_byte)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = boot_addr;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    idx_d   = 5'd0;
                    cnt_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (ack_i) begin
                    cnt_d = '0;
                    if (idx_q == 5'(SEQ_BYTES - 1)) begin
                        state_d = S_FIN;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = S_GAP;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_GAP: begin
                state_d = S_REQ;
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        req_d = (state_d == S_REQ);
        dat_d = req_d ? rom_byte : 8'h00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= 5'd0;
            cnt_q   <= '0;
            addr_q  <= 24'h0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            dat_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            req_q   <= req_d;
            dat_q   <= dat_d;
        end
    end

    assign cyc_o = req_q;
    assign stb_o = req_q;
    assign we_o  = req_q;
    assign dat_o = {24'h000000, dat_q};
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_icap_reboot_wb_master.sv
// Bench for the ICAP reboot initiator: instance 0 (no swap, TIMEOUT=8), instance 1 (swap, TIMEOUT=255).
module tb_icap_reboot_wb_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        start     [2];
    logic [23:0] boot_addr [2];
    logic        cyc [2], stb [2], we [2], busy [2], done [2], err [2];
    logic [31:0] dat [2];
    logic        ack_w [2], sack [2], stray [2], stray_en [2];
    int          sdly [2], scnt [2];

    int          checks = 0;
    int          errors = 0;
    int          cyc_cnt = 0;
    logic [31:0] obs_dat [2][1024];
    int          obs_n [2];
    int          stb_cnt [2];

    typedef struct {
        int          k;
        logic [23:0] addr;
        int          dly;
        bit          e_done;
        bit          e_err;
        int          e_acks;
        int          e_cyc;
        int          e_stb;
    } vec_t;

    vec_t        tbl [6];
    logic [7:0]  nom [20];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt = cyc_cnt + 1;

    icap_reboot_wb_master #(.TIMEOUT(8), .BIT_SWAP(1'b0), .READ_OPCODE(8'h0B)) u_dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .boot_addr(boot_addr[0]),
        .cyc_o(cyc[0]), .stb_o(stb[0]), .we_o(we[0]), .dat_o(dat[0]), .ack_i(ack_w[0]),
        .busy(busy[0]), .done(done[0]), .err(err[0])
    );

    icap_reboot_wb_master #(.TIMEOUT(255), .BIT_SWAP(1'b1), .READ_OPCODE(8'h0B)) u_dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .boot_addr(boot_addr[1]),
        .cyc_o(cyc[1]), .stb_o(stb[1]), .we_o(we[1]), .dat_o(dat[1]), .ack_i(ack_w[1]),
        .busy(busy[1]), .done(done[1]), .err(err[1])
    );

    assign ack_w[0] = sack[0] | stray[0];
    assign ack_w[1] = sack[1] | stray[1];

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: the sequence as a list of 16-bit words, split high byte first.
    function automatic logic [7:0] ref_byte(input int i, input logic [23:0] a, input bit swap);
        logic [15:0] w [10];
        logic [7:0]  b, r;
        w = '{16'hFFFF, 16'hAA99, 16'h3261, a[15:0], 16'h3281, {8'h0B, a[23:16]},
              16'h30A1, 16'h000E, 16'h2000, 16'h2000};
        b = (i % 2 == 0) ? w[i/2][15:8] : w[i/2][7:0];
        for (int j = 0; j < 8; j++) r[j] = swap ? b[7-j] : b[j];
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_side
        logic        p_ack = 1'b0, p_stb = 1'b0;
        logic [31:0] p_dat = '0;

        // Slave: ack goes high sdly cycles after it first sees stb, for one cycle.
        always @(posedge clk or posedge reset) begin
            if (reset) begin
                sack[g] <= 1'b0;
                scnt[g] <= 0;
            end else if (sack[g]) begin
                sack[g] <= 1'b0;
                scnt[g] <= 0;
            end else if (stb[g]) begin
                if (scnt[g] + 1 >= sdly[g]) sack[g] <= 1'b1;
                else scnt[g] <= scnt[g] + 1;
            end else begin
                scnt[g] <= 0;
            end
        end

        always begin
            @(posedge clk);
            #2;
            stray[g] = stray_en[g] && !stb[g];
        end

        always @(negedge clk) begin
            if (p_ack) chk(!stb[g], "stb_after_ack", 32'(stb[g]), 32'd0);
            if (stb[g]) chk(cyc[g] && we[g], "cyc_we_with_stb", {30'd0, cyc[g], we[g]}, 32'd3);
            else chk(dat[g] == 32'd0 && !cyc[g], "idle_bus", dat[g], 32'd0);
            if (stb[g] && p_stb) chk(dat[g] == p_dat, "dat_stable", dat[g], p_dat);
            if (stb[g]) stb_cnt[g] = stb_cnt[g] + 1;
            if (stb[g] && ack_w[g] && obs_n[g] < 1024) begin
                obs_dat[g][obs_n[g]] = dat[g];
                obs_n[g] = obs_n[g] + 1;
            end
            p_ack = stb[g] && ack_w[g];
            p_stb = stb[g];
            p_dat = dat[g];
        end
    end

    task automatic launch(input int k, input logic [23:0] a, output int b0, output int s0, output int t0);
        @(negedge clk);
        #1;
        b0 = obs_n[k];
        s0 = stb_cnt[k];
        boot_addr[k] = a;
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
        t0 = cyc_cnt;
    endtask

    task automatic run_check(input int k, input logic [23:0] a, input int d, input bit e_done,
                             input bit e_err, input int e_acks, input int e_cyc, input int e_stb,
                             output int b0);
        int s0, t0, n, got;
        sdly[k] = d;
        launch(k, a, b0, s0, t0);
        n = 0;
        while (!(done[k] || err[k]) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk(done[k] || err[k], "run_end", 32'(n), 32'd5000);
        chk(done[k] == e_done, "done", 32'(done[k]), 32'(e_done));
        chk(err[k] == e_err, "err", 32'(err[k]), 32'(e_err));
        chk(!busy[k] && !cyc[k], "busy_cyc_low", {30'd0, busy[k], cyc[k]}, 32'd0);
        chk(cyc_cnt - t0 == e_cyc, "cycles", 32'(cyc_cnt - t0), 32'(e_cyc));
        got = obs_n[k] - b0;
        chk(got == e_acks, "acks", 32'(got), 32'(e_acks));
        chk(stb_cnt[k] - s0 == e_stb, "stb_cycles", 32'(stb_cnt[k] - s0), 32'(e_stb));
        for (int i = 0; i < e_acks && i < got; i++)
            chk(obs_dat[k][b0+i] == {24'h0, ref_byte(i, a, k == 1)}, "byte",
                obs_dat[k][b0+i], {24'h0, ref_byte(i, a, k == 1)});
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int b0, s0, t0, n, tmo_lim, d, k;
        logic [23:0] a;

        nom = '{8'hFF, 8'hFF, 8'hAA, 8'h99, 8'h32, 8'h61, 8'h34, 8'h56, 8'h32, 8'h81,
                8'h0B, 8'h12, 8'h30, 8'hA1, 8'h00, 8'h0E, 8'h20, 8'h00, 8'h20, 8'h00};
        tbl[0] = '{0, 24'h123456, 2,    1'b1, 1'b0, 20, 80,  60};
        tbl[1] = '{1, 24'h123456, 2,    1'b1, 1'b0, 20, 80,  60};
        tbl[2] = '{0, 24'h123456, 1000, 1'b0, 1'b1, 0,  8,   8};
        tbl[3] = '{0, 24'hFEDCBA, 7,    1'b1, 1'b0, 20, 180, 160};
        tbl[4] = '{1, 24'h000000, 1,    1'b1, 1'b0, 20, 60,  40};
        tbl[5] = '{0, 24'h800001, 8,    1'b0, 1'b1, 0,  8,   8};

        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; boot_addr[i] = 24'h0; stray_en[i] = 1'b0; sdly[i] = 2;
            obs_n[i] = 0; stb_cnt[i] = 0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk({cyc[i], stb[i], we[i], busy[i], done[i], err[i]} == 6'd0, "reset_flags",
                {26'd0, cyc[i], stb[i], we[i], busy[i], done[i], err[i]}, 32'd0);
            chk(dat[i] == 32'd0, "reset_dat", dat[i], 32'd0);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_check(tbl[i].k, tbl[i].addr, tbl[i].dly, tbl[i].e_done, tbl[i].e_err,
                      tbl[i].e_acks, tbl[i].e_cyc, tbl[i].e_stb, b0);
            if (i == 0)
                for (int j = 0; j < 20; j++)
                    chk(obs_dat[0][b0+j] == {24'h0, nom[j]}, "nominal_stream", obs_dat[0][b0+j], {24'h0, nom[j]});
            if (i == 1) begin
                chk(obs_dat[1][b0+2] == 32'h55, "swap_byte2", obs_dat[1][b0+2], 32'h55);
                chk(obs_dat[1][b0+3] == 32'h99, "swap_byte3", obs_dat[1][b0+3], 32'h99);
                chk(obs_dat[1][b0+6] == 32'h2C, "swap_byte6", obs_dat[1][b0+6], 32'h2C);
            end
        end

        // start while busy at byte 5, then start during FIN
        sdly[0] = 2;
        launch(0, 24'h123456, b0, s0, t0);
        n = 0;
        while (!((obs_n[0] - b0) >= 5 && stb[0]) && n < 2000) begin @(negedge clk); n++; end
        chk(n < 2000, "reach_byte5", 32'(n), 32'd2000);
        boot_addr[0] = 24'hABCDEF;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        n = 0;
        while (!((obs_n[0] - b0) >= 20 && busy[0] && !stb[0]) && n < 2000) begin @(negedge clk); n++; end
        chk(n < 2000, "reach_fin", 32'(n), 32'd2000);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        chk(done[0] && !busy[0] && !err[0], "busy_run_done", {29'd0, done[0], busy[0], err[0]}, 32'd4);
        chk(cyc_cnt - t0 == 80, "busy_run_cycles", 32'(cyc_cnt - t0), 32'd80);
        chk(obs_n[0] - b0 == 20, "busy_run_acks", 32'(obs_n[0] - b0), 32'd20);
        for (int j = 0; j < 20; j++)
            chk(obs_dat[0][b0+j] == {24'h0, ref_byte(j, 24'h123456, 1'b0)}, "busy_run_byte",
                obs_dat[0][b0+j], {24'h0, ref_byte(j, 24'h123456, 1'b0)});
        chk(obs_dat[0][b0+11] == 32'h12, "busy_run_gen2_lo", obs_dat[0][b0+11], 32'h12);
        @(negedge clk);
        chk(!stb[0] && !busy[0] && done[0], "start_in_fin_ignored", {29'd0, stb[0], busy[0], done[0]}, 32'd1);

        // stray acks in IDLE and in every GAP/FIN cycle
        stray_en[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk(!busy[0] && !stb[0] && done[0], "stray_idle", {29'd0, busy[0], stb[0], done[0]}, 32'd1);
        run_check(0, 24'h5A5A5A, 2, 1'b1, 1'b0, 20, 80, 60, b0);
        stray_en[0] = 1'b0;

        // asynchronous reset in the middle of byte 9
        launch(0, 24'h123456, b0, s0, t0);
        n = 0;
        while (!((obs_n[0] - b0) >= 9 && stb[0]) && n < 2000) begin @(negedge clk); n++; end
        chk(n < 2000, "reach_byte9", 32'(n), 32'd2000);
        #1 reset = 1'b1;
        #1;
        chk(!cyc[0] && !stb[0] && !busy[0], "async_drop", {29'd0, cyc[0], stb[0], busy[0]}, 32'd0);
        chk(dat[0] == 32'd0, "async_dat", dat[0], 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk({busy[0], done[0], err[0], stb[0]} == 4'd0, "post_reset_flags",
            {28'd0, busy[0], done[0], err[0], stb[0]}, 32'd0);
        run_check(0, 24'h123456, 2, 1'b1, 1'b0, 20, 80, 60, b0);

        // randomized runs against the reference model
        for (int r = 0; r < 12; r++) begin
            k = $urandom_range(0, 1);
            a = 24'($urandom);
            d = $urandom_range(1, 9);
            tmo_lim = (k == 0) ? 8 : 255;
            if (d >= tmo_lim)
                run_check(k, a, d, 1'b0, 1'b1, 0, tmo_lim, tmo_lim, b0);
            else
                run_check(k, a, d, 1'b1, 1'b0, 20, 20 * (d + 2), 20 * (d + 1), b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/icap_reboot_wb_master.md
Name: icap_reboot_wb_master

Overview:
- Wishbone initiator that drives the byte-wide ICAP Wishbone slave to perform a Spartan-3A multiboot reboot.
- On a start pulse, it streams the fixed ICAP command sequence to the slave as one write transaction per byte: dummy, sync, GENERAL1/2 carrying the boot address, CMD=REBOOT, then NOOPs.
- It sits between the firmware control register bank and the ICAP slave, so the CPU can trigger a reboot into an alternate image with one register write.

Parameters:
- TIMEOUT, 255: maximum cycles to wait for ack_i per transaction before aborting.
- BIT_SWAP, 1: when 1, reverse bit order within each byte before output, as the Spartan-3A ICAP requires.
- READ_OPCODE, 8'h0B: SPI flash read opcode placed in GENERAL2[15:8].

Ports:
- clk, input, 1: system clock.
- reset, input, 1: reset, asynchronous and active-high.
- start, input, 1: single-cycle pulse that launches the sequence. Ignored while busy.
- boot_addr, input, 24: flash address of the target image. Latched on an accepted start.
- cyc_o, output, 1: Wishbone cycle.
- stb_o, output, 1: Wishbone strobe.
- we_o, output, 1: Wishbone write enable. Always 1 during transactions.
- dat_o, output, 32: write data. Bits [31:8] are 0; bits [7:0] carry the sequence byte.
- ack_i, input, 1: Wishbone acknowledge from the ICAP slave.
- busy, output, 1: high from an accepted start until DONE or ERR.
- done, output, 1: sticky flag, set when the last byte is acked. Cleared by the next accepted start.
- err, output, 1: sticky flag, set on timeout. Cleared by the next accepted start.

Behaviour:
- Reset (asynchronous) forces all of the following to 0 immediately, with no bus handshake completion: cyc_o, stb_o, we_o, dat_o, busy, done, err, byte index, timeout counter.
- Sequence: 10 words, sent high byte first, giving 20 bytes (byte index 0..19):
  - FFFF, AA99, 3261, boot_addr[15:0], 3281, {READ_OPCODE, boot_addr[23:16]}, 30A1, 000E, 2000, 2000.
- States: IDLE, REQ, GAP, FIN.
- IDLE:
  - Outputs low.
  - On start, latch boot_addr, clear done/err, set busy, set index=0, and go to REQ.
- REQ:
  - cyc_o=stb_o=we_o=1; dat_o[7:0] = byte[index], bit-reversed if BIT_SWAP.
  - The timeout counter increments each cycle.
  - If ack_i is sampled high at a rising edge:
    - If index==19, go to FIN.
    - Otherwise increment index, clear the counter, and go to GAP.
  - If the counter reaches TIMEOUT without ack_i, set err, clear busy, and go to IDLE. done stays 0.
- GAP:
  - cyc_o=stb_o=0 for exactly one cycle, so the slave returns to its idle state before the next strobe.
  - Then go to REQ.
- FIN: set done, clear busy, drop cyc/stb, and go to IDLE.
- The cycle after ack_i is sampled always has stb_o=0. stb_o is never held through a second slave transaction.
- All outputs are registered. stb_o rises the cycle after start is accepted.
- Timing against the ICAP slave (ack two cycles after stb): 3 REQ cycles + 1 GAP cycle per byte, so 80 cycles from start to done.
- ack_i outside REQ is ignored.
- start while busy is ignored, and boot_addr is not re-latched.
- start in the same cycle as FIN is ignored. start is accepted only in IDLE.
- dat_o holds its value for the whole of REQ and returns to 0 outside REQ.

Decomposition:
- Shared package icap_pkg holds:
  - state encoding;
  - sequence word constants: ICAP_DUMMY=16'hFFFF, ICAP_SYNC=16'hAA99, ICAP_WR_GEN1=16'h3261, ICAP_WR_GEN2=16'h3281, ICAP_WR_CMD=16'h30A1, ICAP_CMD_REBOOT=16'h000E, ICAP_NOOP=16'h2000;
  - SEQ_BYTES=20.
- One sub-module, icap_seq_rom: combinational mapping of index[4:0], boot_addr and READ_OPCODE to a byte, with the BIT_SWAP reversal applied.

Test Plan:
- Nominal: BIT_SWAP=0, boot_addr=24'h123456, slave model acks two cycles after stb.
  - Required byte stream: FF FF AA 99 32 61 34 56 32 81 0B 12 30 A1 00 0E 20 00 20 00.
  - done=1 at cycle 80, err=0, busy low after done.
- BIT_SWAP=1, same address:
  - Byte 2 = 8'h55 (AA reversed), byte 3 = 8'h99, byte 6 = 8'h2C (34 reversed).
  - 20 transactions total.
- Timeout: TIMEOUT=8, slave never acks.
  - stb_o stays high for 8 cycles on byte 0, then err=1, busy=0, done=0, cyc_o=0.
- start during busy: pulse start with boot_addr=24'hABCDEF at byte 5 of a run launched with 24'h123456.
  - The sequence still emits 34 56 and 0B 12.
  - Exactly 20 acks occur; done pulses once.
- Async reset asserted mid-REQ at byte 9:
  - cyc_o/stb_o drop within the same cycle, before the next clk edge.
  - After release, all flags are 0; a new start produces a full 20-byte sequence from byte 0.
- Stray ack_i pulses in IDLE and GAP:
  - No index advance, no state change.
  - The subsequent sequence is unchanged.
